pc_sequencer: RTL and testbench

- Parametrised next-generation program-counter sequencer for the 19-bit CPU family.
- Computes the next PC from decoded control strobes: jump, conditional relative branch, call and return.
- Adds a hardware return-address stack (RAS), a pipeline stall hold, and sticky overflow/underflow error flags.
- Sits between the control unit/ALU zero flag and the instruction-fetch stage.

---
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: jump / relative branch / call / return with a
// hardware return-address stack, stall hold and sticky stack error flags.
module pc_sequencer #(
  parameter int ADDR_W      = 19,
  parameter int OFF_W       = 15,
  parameter int STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int CNT_W      = $clog2(STACK_DEPTH+1),
  localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump,
  input  logic              branch,
  input  logic              zero,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  input  logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  ras_count,
  output logic              ras_full,
  output logic              ras_empty,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf, r_unf;
  logic [STACK_DEPTH-1:0][ADDR_W-1:0] r_ras;

  logic [ADDR_W-1:0] w_pc_inc, w_off_sext, w_pc_nxt;
  logic [CNT_W-1:0]  w_cnt_m1, w_cnt_nxt;
  logic [IDX_W-1:0]  w_push_idx, w_top_idx;
  logic              w_full, w_empty, w_push, w_set_ovf, w_set_unf;

  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_off_sext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign w_full     = (r_count == CNT_W'(STACK_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_cnt_m1   = r_count - CNT_W'(1);
  // Push slot is the current count; only used when not full, so it fits IDX_W.
  assign w_push_idx = IDX_W'(r_count);
  assign w_top_idx  = IDX_W'(w_cnt_m1);

  always_comb begin
    w_pc_nxt  = w_pc_inc;
    w_cnt_nxt = r_count;
    w_push    = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (jump) begin
      w_pc_nxt = target;
    end else if (branch && zero) begin
      w_pc_nxt = r_pc + w_off_sext;
    end else if (call) begin
      w_pc_nxt = target;
      if (w_full) begin
        w_set_ovf = 1'b1;
      end else begin
        w_push    = 1'b1;
        w_cnt_nxt = r_count + CNT_W'(1);
      end
    end else if (ret) begin
      if (w_empty) begin
        w_set_unf = 1'b1;
      end else begin
        w_pc_nxt  = r_ras[w_top_idx];
        w_cnt_nxt = w_cnt_m1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!stall) begin
      r_pc    <= w_pc_nxt;
      r_count <= w_cnt_nxt;
      r_ovf   <= r_ovf | w_set_ovf;
      r_unf   <= r_unf | w_set_unf;
    end
  end

  // Stack storage needs no reset; its contents are only read below r_count.
  always_ff @(posedge clk) begin
    if (!reset && !stall && w_push) r_ras[w_push_idx] <= w_pc_inc;
  end

  assign pc        = r_pc;
  assign ras_count = r_count;
  assign ras_full  = w_full;
  assign ras_empty = w_empty;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer against a queue-based model.
module tb_pc_sequencer;
  localparam int AW = 19, OW = 15, D = 8, CW = $clog2(D+1);
  localparam logic [AW-1:0] RPC = '0;

  logic clk = 1'b0;
  logic reset, stall, jump, branch, zero, call, ret;
  logic [AW-1:0] target;
  logic [OW-1:0] offset;
  logic [AW-1:0] pc;
  logic [CW-1:0] ras_count;
  logic ras_full, ras_empty, overflow, underflow;

  int errs = 0, checks = 0;

  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_ras[$];
  logic m_ovf, m_unf;

  pc_sequencer #(.ADDR_W(AW), .OFF_W(OW), .STACK_DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .branch(branch),
    .zero(zero), .call(call), .ret(ret), .target(target), .offset(offset),
    .pc(pc), .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty),
    .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (!stall) begin
      if (jump) m_pc = target;
      else if (branch && zero) m_pc = m_pc + AW'($signed(offset));
      else if (call) begin
        if (m_ras.size() < D) m_ras.push_back(m_pc + 1'b1);
        else m_ovf = 1'b1;
        m_pc = target;
      end else if (ret) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = m_pc + 1'b1; m_unf = 1'b1; end
      end else m_pc = m_pc + 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".cnt"}, ras_count, m_ras.size());
    chk({tag, ".full"}, ras_full, m_ras.size() == D);
    chk({tag, ".empty"}, ras_empty, m_ras.size() == 0);
    chk({tag, ".ovf"}, overflow, m_ovf);
    chk({tag, ".unf"}, underflow, m_unf);
  endtask

  task automatic drive(input logic j, b, z, c, r, s, input logic [AW-1:0] t, input logic [OW-1:0] o);
    jump = j; branch = b; zero = z; call = c; ret = r; stall = s; target = t; offset = o;
  endtask

  task automatic cyc(input string tag);
    @(posedge clk); #1;
    model_step();
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    repeat (n) cyc(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    cyc("reset");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    model_reset();
    #2; check_all("por");
    do_reset();
    chk("reset.pc0", pc, 0);
    idle(4, "seq");
    chk("seq.pc4", pc, 4);

    // Branch taken backwards by 2, then untaken.
    do_reset(); idle(10, "to10");
    drive(0, 1, 1, 0, 0, 0, '0, 15'h7FFE); cyc("br_taken");
    chk("br_taken.pc8", pc, 8);
    idle(2, "to10b");
    drive(0, 1, 0, 0, 0, 0, '0, 15'h7FFE); cyc("br_untaken");
    chk("br_untaken.pc11", pc, 11);

    // Call / return.
    do_reset(); idle(5, "to5");
    drive(0, 0, 0, 1, 0, 0, 19'h100, '0); cyc("call");
    chk("call.pc", pc, 19'h100); chk("call.cnt1", ras_count, 1);
    idle(3, "body");
    chk("body.pc", pc, 19'h103);
    drive(0, 0, 0, 0, 1, 0, '0, '0); cyc("ret");
    chk("ret.pc6", pc, 6); chk("ret.cnt0", ras_count, 0);

    // Nested calls beyond depth, then unwind past empty.
    do_reset();
    for (int k = 1; k <= D + 1; k++) begin
      drive(0, 0, 0, 1, 0, 0, AW'(32'h1000 * k + k), '0); cyc("nest_call");
    end
    chk("nest.ovf", overflow, 1); chk("nest.cnt8", ras_count, D);
    for (int k = 0; k < D; k++) begin
      drive(0, 0, 0, 0, 1, 0, '0, '0); cyc("nest_ret");
    end
    chk("unwind.pc1", pc, 1);
    cyc("ret_empty");
    chk("ret_empty.pc2", pc, 2); chk("ret_empty.unf", underflow, 1);

    // Priority and stall.
    drive(0, 0, 0, 1, 0, 0, 19'h200, '0); cyc("pre_call");
    drive(1, 0, 0, 1, 1, 0, 19'h40, '0); cyc("jcr");
    chk("jcr.pc", pc, 19'h40); chk("jcr.cnt", ras_count, 1);
    drive(0, 0, 0, 1, 0, 1, 19'h500, '0); cyc("stall");
    chk("stall.pc", pc, 19'h40); chk("stall.cnt", ras_count, 1);

    // Async reset between edges during a call sequence.
    drive(0, 0, 0, 1, 0, 0, 19'h300, '0); cyc("call2");
    #3 reset = 1'b1;
    #1 model_reset(); check_all("async_rst");
    chk("async_rst.pc", pc, RPC);
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    cyc("rst_hold");
    reset = 1'b0;

    // PC wrap.
    drive(1, 0, 0, 0, 0, 0, 19'h7FFFF, '0); cyc("to_max");
    idle(1, "wrap");
    chk("wrap.pc0", pc, 0);

    // Randomized mix weighted toward call/ret to exercise full/empty.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom;
      reset = ($urandom_range(0, 299) == 0);
      drive(r[2:0] == 0, r[5:3] == 0, r[6], r[9:7] < 3, r[12:10] < 3, r[15:13] == 0,
            AW'($urandom), OW'($urandom));
      cyc("rand");
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
